// File: rtl/program_counter.sv
// Instruction-address register: synchronous active-low reset, parallel load, increment, load-and-increment.
// Optional registered overflow flag `wrap` is enabled by defining PC_WRAP_FLAG_EN.
module program_counter #(
    parameter int unsigned            WIDTH       = 8,
    parameter logic [WIDTH-1:0]       RESET_VALUE = '0,
    parameter logic [WIDTH-1:0]       INC_STEP    = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             LoadPC,
    input  logic             IncPC,
    input  logic [WIDTH-1:0] new_count,
`ifdef PC_WRAP_FLAG_EN
    output logic             wrap,
`endif
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] inc_base;
    logic [WIDTH-1:0] inc_value;

    // Load-and-increment adds the step to the incoming target, not to the current PC.
    assign inc_base = LoadPC ? new_count : count;

`ifdef PC_WRAP_FLAG_EN
    logic inc_carry;
    assign {inc_carry, inc_value} = {1'b0, inc_base} + {1'b0, INC_STEP};
`else
    assign inc_value = inc_base + INC_STEP;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= RESET_VALUE;
        end else if (IncPC) begin
            count <= inc_value;
        end else if (LoadPC) begin
            count <= new_count;
        end
    end

`ifdef PC_WRAP_FLAG_EN
    // Flag is raised only by an overflowing increment; loads and holds clear it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wrap <= 1'b0;
        end else begin
            wrap <= IncPC & inc_carry;
        end
    end
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed test-plan sequence plus randomized traffic,
// checked through an expected-value queue consumed by an independent monitor.
module tb_program_counter;

    localparam int unsigned      W      = 8;
    localparam logic [W-1:0]     RST_V  = 8'h00;
    localparam logic [W-1:0]     STEP   = 8'h01;
    localparam longint           MODULUS = longint'(1) << W;

    typedef struct packed {
        logic [W-1:0] count;
        logic         wrap;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         LoadPC;
    logic         IncPC;
    logic [W-1:0] new_count;
    logic [W-1:0] count;
`ifdef PC_WRAP_FLAG_EN
    logic         wrap;
`endif

    program_counter #(
        .WIDTH      (W),
        .RESET_VALUE(RST_V),
        .INC_STEP   (STEP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .LoadPC   (LoadPC),
        .IncPC    (IncPC),
        .new_count(new_count),
`ifdef PC_WRAP_FLAG_EN
        .wrap     (wrap),
`endif
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    longint m_pc     = 0;
    logic   m_wrap   = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: the priority rules applied with plain modular arithmetic.
    task automatic step(input logic r, input logic l, input logic i, input logic [W-1:0] nc);
        longint sum;
        @(negedge clk);
        reset     = r;
        LoadPC    = l;
        IncPC     = i;
        new_count = nc;
        if (!r) begin
            m_pc   = longint'(RST_V);
            m_wrap = 1'b0;
        end else if (i) begin
            sum    = (l ? longint'(nc) : m_pc) + longint'(STEP);
            m_wrap = (sum >= MODULUS);
            m_pc   = sum % MODULUS;
        end else begin
            if (l) m_pc = longint'(nc);
            m_wrap = 1'b0;
        end
        exp_q.push_back(exp_t'{count: W'(m_pc), wrap: m_wrap});
    endtask

    // Monitor: one expected entry per active edge, compared just after that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("count", 32'(count), 32'(e.count));
`ifdef PC_WRAP_FLAG_EN
                check("wrap", 32'(wrap), 32'(e.wrap));
`endif
            end
        end
    end

    initial begin
        logic [W-1:0] nc;
        int           sel;
        reset     = 1'b1;
        LoadPC    = 1'b0;
        IncPC     = 1'b0;
        new_count = '0;

        // Reset ignores load/target.
        step(1'b0, 1'b1, 1'b0, 8'hA5);
        // Load then hold.
        step(1'b1, 1'b1, 1'b0, 8'h3C);
        repeat (3) step(1'b1, 1'b0, 1'b0, 8'h77);
        // Increment with target ignored.
        repeat (3) step(1'b1, 1'b0, 1'b1, 8'h00);
        // Load-and-increment.
        step(1'b1, 1'b1, 1'b1, 8'h10);
        // Wrap through FF -> 00.
        step(1'b1, 1'b1, 1'b0, 8'hFE);
        repeat (2) step(1'b1, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        // Load-and-increment overflow.
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        // Reset mid-count, then resume.
        step(1'b1, 1'b1, 1'b0, 8'h04);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h00);

        // Randomized traffic, biased toward the top of the address range to exercise wrap.
        for (int k = 0; k < 400; k++) begin
            sel = int'($urandom_range(0, 3));
            nc  = (sel == 0) ? 8'hFF : (sel == 1) ? 8'hFE : W'($urandom);
            step(($urandom_range(0, 15) != 0), 1'($urandom), 1'($urandom), nc);
        end

        // Drain the scoreboard within a bounded number of edges.
        for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(posedge clk);
        #2;
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
